// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 register file plus exception/ERET sequencer for the 5-stage
// MIPS32 core. Resolves traps for the MEM instruction and redirects fetch.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter logic [31:0] RESET_STATUS = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  HWInt,
  input  logic        MEMValid,
  input  logic [31:0] MEMPC,
  input  logic        MEMInDelaySlot,
  input  logic [6:0]  MEMExc,
  input  logic [31:0] MEMBadAddr,
  input  logic        MEMIsEret,
  input  logic        WBCP0We,
  input  logic [4:0]  WBCP0WAddr,
  input  logic [31:0] WBCP0WData,
  input  logic [4:0]  RAddr,
  output logic [31:0] RData,
  output logic        MEMKill,
  output logic        Flush,
  output logic        RedirectValid,
  output logic [31:0] RedirectPC,
  output logic [31:0] StatusOut,
  output logic [31:0] EPCOut
);
  localparam logic [31:0] STATUS_WMASK = 32'h0040FF03;

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    EXC_FLUSH  = 2'd1,
    ERET_FLUSH = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] badvaddr_reg, count_reg, compare_reg, status_reg, cause_reg, epc_reg;
  logic [31:0] redirect_pc_reg;
  logic [31:0] status_next, cause_next, epc_next, count_next;
  logic        toggle_reg, timer_pend_reg;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        int_req, exc_taken, eret_taken, exc_is_addr, flush_state;
  logic [4:0]  exc_code;

  assign wr_count   = WBCP0We && (WBCP0WAddr == 5'd9);
  assign wr_compare = WBCP0We && (WBCP0WAddr == 5'd11);
  assign wr_status  = WBCP0We && (WBCP0WAddr == 5'd12);
  assign wr_cause   = WBCP0We && (WBCP0WAddr == 5'd13);
  assign wr_epc     = WBCP0We && (WBCP0WAddr == 5'd14);

  assign int_req    = MEMValid & status_reg[0] & ~status_reg[1]
                    & (|(cause_reg[15:8] & status_reg[15:8]));
  assign exc_taken  = (state_reg == NORMAL) & MEMValid & ((|MEMExc) | int_req);
  assign eret_taken = (state_reg == NORMAL) & MEMValid & MEMIsEret & ~exc_taken;
  assign MEMKill    = exc_taken;

  // Fixed priority: fetch fault first, data address faults last, interrupt as fallback.
  always_comb begin
    exc_code    = 5'd0;
    exc_is_addr = 1'b0;
    if (MEMExc[6]) begin
      exc_code    = 5'd4;
      exc_is_addr = 1'b1;
    end else if (MEMExc[5]) begin
      exc_code = 5'd10;
    end else if (MEMExc[4]) begin
      exc_code = 5'd12;
    end else if (MEMExc[3]) begin
      exc_code = 5'd8;
    end else if (MEMExc[2]) begin
      exc_code = 5'd9;
    end else if (MEMExc[1]) begin
      exc_code    = 5'd4;
      exc_is_addr = 1'b1;
    end else if (MEMExc[0]) begin
      exc_code    = 5'd5;
      exc_is_addr = 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    flush_state = 1'b0;
    case (state_reg)
      NORMAL: begin
        if (exc_taken)       state_next = EXC_FLUSH;
        else if (eret_taken) state_next = ERET_FLUSH;
      end
      EXC_FLUSH: begin
        flush_state = 1'b1;
        state_next  = NORMAL;
      end
      ERET_FLUSH: begin
        flush_state = 1'b1;
        state_next  = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  // Trap side effects are applied after mtc0 so they override the fields they own.
  always_comb begin
    status_next = status_reg;
    if (wr_status)
      status_next = (status_reg & ~STATUS_WMASK) | (WBCP0WData & STATUS_WMASK);
    if (exc_taken)       status_next[1] = 1'b1;
    else if (eret_taken) status_next[1] = 1'b0;

    cause_next        = cause_reg;
    cause_next[15:10] = {HWInt[5] | timer_pend_reg, HWInt[4:0]};
    if (wr_cause) cause_next[9:8] = WBCP0WData[9:8];
    if (exc_taken) begin
      cause_next[6:2] = exc_code;
      if (!status_reg[1]) cause_next[31] = MEMInDelaySlot;
    end

    epc_next = epc_reg;
    if (wr_epc) epc_next = WBCP0WData;
    if (exc_taken && !status_reg[1])
      epc_next = MEMInDelaySlot ? (MEMPC - 32'd4) : MEMPC;

    count_next = count_reg;
    if (wr_count)        count_next = WBCP0WData;
    else if (toggle_reg) count_next = count_reg + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= NORMAL;
      badvaddr_reg    <= 32'd0;
      count_reg       <= 32'd0;
      compare_reg     <= 32'd0;
      status_reg      <= RESET_STATUS;
      cause_reg       <= 32'd0;
      epc_reg         <= 32'd0;
      redirect_pc_reg <= 32'd0;
      toggle_reg      <= 1'b0;
      timer_pend_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      status_reg <= status_next;
      cause_reg  <= cause_next;
      epc_reg    <= epc_next;
      count_reg  <= count_next;
      toggle_reg <= ~toggle_reg;
      if (wr_compare) compare_reg <= WBCP0WData;
      if (wr_compare)                    timer_pend_reg <= 1'b0;
      else if (count_reg == compare_reg) timer_pend_reg <= 1'b1;
      if (exc_taken && exc_is_addr) badvaddr_reg <= MEMBadAddr;
      if (exc_taken)       redirect_pc_reg <= EXC_VECTOR;
      else if (eret_taken) redirect_pc_reg <= epc_reg;
    end
  end

  always_comb begin
    case (RAddr)
      5'd8:    RData = badvaddr_reg;
      5'd9:    RData = count_reg;
      5'd11:   RData = compare_reg;
      5'd12:   RData = status_reg;
      5'd13:   RData = cause_reg;
      5'd14:   RData = epc_reg;
      default: RData = 32'd0;
    endcase
  end

  assign Flush         = flush_state;
  assign RedirectValid = flush_state;
  assign RedirectPC    = redirect_pc_reg;
  assign StatusOut     = status_reg;
  assign EPCOut        = epc_reg;

endmodule
